// File: rtl/wb_pkg.sv
// Shared definitions for the non-blocking writeback stage.
//   TRIM_*      : load-width encodings carried in the MemTrim control field
//   lq_entry_t  : one load-queue slot (destination, extraction controls,
//                 write-enable, completion flag and extracted data)
package wb_pkg;

  localparam int WB_XLEN      = 32;
  localparam int WB_REG_ADR_W = 5;

  localparam logic [1:0] TRIM_WORD = 2'b00;
  localparam logic [1:0] TRIM_HALF = 2'b01;
  localparam logic [1:0] TRIM_BYTE = 2'b10;

  typedef struct packed {
    logic [WB_REG_ADR_W-1:0] rd;
    logic                    sign;
    logic [1:0]              trim;
    logic [1:0]              ofs;
    logic                    we;
    logic                    done;
    logic [WB_XLEN-1:0]      data;
  } lq_entry_t;

endpackage

// File: rtl/wb_lane_extract.sv
// Combinational load-data formatter: selects the addressed byte/half lane
// of a raw memory word and zero- or sign-extends it to XLEN.
//   ofs      : load address bits [1:0]
//   trim     : TRIM_WORD / TRIM_HALF / TRIM_BYTE (11 behaves as word)
//   sign     : 1 = sign-extend, 0 = zero-extend
//   data     : raw memory word
//   ext_data : formatted register-file value
module wb_lane_extract
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      ofs,
  input  logic [1:0]      trim,
  input  logic            sign,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] ext_data
);

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;

  always_comb begin
    case (ofs)
      2'd0:    byte_lane = data[7:0];
      2'd1:    byte_lane = data[15:8];
      2'd2:    byte_lane = data[23:16];
      default: byte_lane = data[31:24];
    endcase
    // Misaligned halves are trapped upstream, so only ofs[1] picks the lane.
    half_lane = ofs[1] ? data[31:16] : data[15:0];

    case (trim)
      TRIM_BYTE: ext_data = {{(XLEN-8){sign & byte_lane[7]}}, byte_lane};
      TRIM_HALF: ext_data = {{(XLEN-16){sign & half_lane[15]}}, half_lane};
      default:   ext_data = data;
    endcase
  end

endmodule

// File: rtl/wb_stage_nb.sv
// Non-blocking writeback stage. Drives the single register-file write port
// from either the ALU result in MEM/WB (same cycle, highest priority) or the
// head of an in-order load queue whose memory response has arrived.
//   mem_wb_reg_*              : instruction currently in MEM/WB
//   dmem_rsp_valid/data       : in-order load responses from data memory
//   wb_stage_wb_ctrl_RegWrite : register-file write enable
//   wb_stage_rd_adr           : register-file write address
//   wb_stage_reg_file_wr_data : register-file write data
//   wb_stage_lq_full/empty    : load-queue occupancy flags (registered state)
//   wb_stage_rd_pending       : destinations of queued loads, for the hazard unit
//   wb_stage_lq_err           : sticky overflow / spurious-response flag
module wb_stage_nb
  import wb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LQ_DEPTH  = 4,
  parameter int REG_ADR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_wb_reg_valid,
  input  logic [XLEN-1:0]           mem_wb_reg_alu_result,
  input  logic [REG_ADR_W-1:0]      mem_wb_reg_rd_adr,
  input  logic [1:0]                mem_wb_reg_byte_ofs,
  input  logic                      mem_wb_reg_wb_ctrl_RegWrite,
  input  logic                      mem_wb_reg_wb_ctrl_MemtoReg,
  input  logic                      mem_wb_reg_wb_ctrl_MemSign,
  input  logic [1:0]                mem_wb_reg_wb_ctrl_MemTrim,
  input  logic                      dmem_rsp_valid,
  input  logic [XLEN-1:0]           dmem_rsp_data,
  output logic                      wb_stage_wb_ctrl_RegWrite,
  output logic [REG_ADR_W-1:0]      wb_stage_rd_adr,
  output logic [XLEN-1:0]           wb_stage_reg_file_wr_data,
  output logic                      wb_stage_lq_full,
  output logic                      wb_stage_lq_empty,
  output logic [2**REG_ADR_W-1:0]   wb_stage_rd_pending,
  output logic                      wb_stage_lq_err
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lq_entry_t            lq_mem [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]  lq_vld;
  logic [PTR_W-1:0]     alloc_ptr;
  logic [PTR_W-1:0]     rsp_ptr;
  logic [PTR_W-1:0]     ret_ptr;
  logic [CNT_W-1:0]     count;
  logic                 lq_err_q;

  logic                 load_req;
  logic                 alloc;
  logic                 rsp_hit;
  logic                 alu_wr;
  logic                 retire;
  lq_entry_t            rsp_entry;
  lq_entry_t            ret_entry;
  logic [XLEN-1:0]      rsp_ext;

  assign wb_stage_lq_full  = (count == CNT_W'(LQ_DEPTH));
  assign wb_stage_lq_empty = (count == '0);
  assign wb_stage_lq_err   = lq_err_q;

  assign rsp_entry = lq_mem[rsp_ptr];
  assign ret_entry = lq_mem[ret_ptr];

  // Loads allocate even when they do not write rd, so every response
  // always has a slot to land in.
  assign load_req = mem_wb_reg_valid & mem_wb_reg_wb_ctrl_MemtoReg;
  assign alloc    = load_req & ~wb_stage_lq_full;

  // rsp_ptr always rests on the oldest undone entry; if that slot is empty
  // or already done there is nothing outstanding and the response is spurious.
  assign rsp_hit  = dmem_rsp_valid & lq_vld[rsp_ptr] & ~rsp_entry.done;

  assign alu_wr   = mem_wb_reg_valid & ~mem_wb_reg_wb_ctrl_MemtoReg &
                    mem_wb_reg_wb_ctrl_RegWrite & (mem_wb_reg_rd_adr != '0);
  assign retire   = ~alu_wr & lq_vld[ret_ptr] & ret_entry.done;

  wb_lane_extract #(.XLEN(XLEN)) u_lane_extract (
    .ofs      (rsp_entry.ofs),
    .trim     (rsp_entry.trim),
    .sign     (rsp_entry.sign),
    .data     (dmem_rsp_data),
    .ext_data (rsp_ext)
  );

  always_comb begin
    wb_stage_wb_ctrl_RegWrite = 1'b0;
    wb_stage_rd_adr           = mem_wb_reg_rd_adr;
    wb_stage_reg_file_wr_data = mem_wb_reg_alu_result;
    if (alu_wr) begin
      wb_stage_wb_ctrl_RegWrite = 1'b1;
    end else if (retire) begin
      wb_stage_wb_ctrl_RegWrite = ret_entry.we;
      wb_stage_rd_adr           = ret_entry.rd;
      wb_stage_reg_file_wr_data = ret_entry.data;
    end
  end

  // A retiring entry is still valid this cycle, so it keeps its pending bit.
  always_comb begin
    wb_stage_rd_pending = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lq_vld[i] && lq_mem[i].we) wb_stage_rd_pending[lq_mem[i].rd] = 1'b1;
    end
  end

  // Queue state: control bits reset, payload fields only written on use.
  // Alloc, response and retire always touch distinct slots in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lq_vld    <= '0;
      alloc_ptr <= '0;
      rsp_ptr   <= '0;
      ret_ptr   <= '0;
      count     <= '0;
      lq_err_q  <= 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) lq_mem[i].done <= 1'b0;
    end else begin
      if (alloc) begin
        lq_mem[alloc_ptr].rd   <= mem_wb_reg_rd_adr;
        lq_mem[alloc_ptr].sign <= mem_wb_reg_wb_ctrl_MemSign;
        lq_mem[alloc_ptr].trim <= mem_wb_reg_wb_ctrl_MemTrim;
        lq_mem[alloc_ptr].ofs  <= mem_wb_reg_byte_ofs;
        lq_mem[alloc_ptr].we   <= mem_wb_reg_wb_ctrl_RegWrite &
                                  (mem_wb_reg_rd_adr != '0);
        lq_mem[alloc_ptr].done <= 1'b0;
        lq_vld[alloc_ptr]      <= 1'b1;
        alloc_ptr              <= alloc_ptr + 1'b1;
      end
      if (rsp_hit) begin
        lq_mem[rsp_ptr].data <= rsp_ext;
        lq_mem[rsp_ptr].done <= 1'b1;
        rsp_ptr              <= rsp_ptr + 1'b1;
      end
      if (retire) begin
        lq_vld[ret_ptr] <= 1'b0;
        ret_ptr         <= ret_ptr + 1'b1;
      end
      case ({alloc, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((load_req & wb_stage_lq_full) | (dmem_rsp_valid & ~rsp_hit))
        lq_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage_nb.sv
module tb_wb_stage_nb;
  import wb_pkg::*;

  localparam int XLEN      = 32;
  localparam int LQ_DEPTH  = 4;
  localparam int REG_ADR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              mem_wb_reg_valid;
  logic [31:0]       mem_wb_reg_alu_result;
  logic [4:0]        mem_wb_reg_rd_adr;
  logic [1:0]        mem_wb_reg_byte_ofs;
  logic              mem_wb_reg_wb_ctrl_RegWrite;
  logic              mem_wb_reg_wb_ctrl_MemtoReg;
  logic              mem_wb_reg_wb_ctrl_MemSign;
  logic [1:0]        mem_wb_reg_wb_ctrl_MemTrim;
  logic              dmem_rsp_valid;
  logic [31:0]       dmem_rsp_data;
  logic              wb_stage_wb_ctrl_RegWrite;
  logic [4:0]        wb_stage_rd_adr;
  logic [31:0]       wb_stage_reg_file_wr_data;
  logic              wb_stage_lq_full;
  logic              wb_stage_lq_empty;
  logic [31:0]       wb_stage_rd_pending;
  logic              wb_stage_lq_err;

  wb_stage_nb #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH), .REG_ADR_W(REG_ADR_W)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .mem_wb_reg_valid            (mem_wb_reg_valid),
    .mem_wb_reg_alu_result       (mem_wb_reg_alu_result),
    .mem_wb_reg_rd_adr           (mem_wb_reg_rd_adr),
    .mem_wb_reg_byte_ofs         (mem_wb_reg_byte_ofs),
    .mem_wb_reg_wb_ctrl_RegWrite (mem_wb_reg_wb_ctrl_RegWrite),
    .mem_wb_reg_wb_ctrl_MemtoReg (mem_wb_reg_wb_ctrl_MemtoReg),
    .mem_wb_reg_wb_ctrl_MemSign  (mem_wb_reg_wb_ctrl_MemSign),
    .mem_wb_reg_wb_ctrl_MemTrim  (mem_wb_reg_wb_ctrl_MemTrim),
    .dmem_rsp_valid              (dmem_rsp_valid),
    .dmem_rsp_data               (dmem_rsp_data),
    .wb_stage_wb_ctrl_RegWrite   (wb_stage_wb_ctrl_RegWrite),
    .wb_stage_rd_adr             (wb_stage_rd_adr),
    .wb_stage_reg_file_wr_data   (wb_stage_reg_file_wr_data),
    .wb_stage_lq_full            (wb_stage_lq_full),
    .wb_stage_lq_empty           (wb_stage_lq_empty),
    .wb_stage_rd_pending         (wb_stage_rd_pending),
    .wb_stage_lq_err             (wb_stage_lq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_wb_reg_valid            = 1'b0;
    mem_wb_reg_alu_result       = '0;
    mem_wb_reg_rd_adr           = '0;
    mem_wb_reg_byte_ofs         = '0;
    mem_wb_reg_wb_ctrl_RegWrite = 1'b0;
    mem_wb_reg_wb_ctrl_MemtoReg = 1'b0;
    mem_wb_reg_wb_ctrl_MemSign  = 1'b0;
    mem_wb_reg_wb_ctrl_MemTrim  = '0;
    dmem_rsp_valid              = 1'b0;
    dmem_rsp_data               = '0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [1:0] ofs,
                          input logic [1:0] trim, input logic sign);
    mem_wb_reg_valid            = 1'b1;
    mem_wb_reg_wb_ctrl_MemtoReg = 1'b1;
    mem_wb_reg_wb_ctrl_RegWrite = 1'b1;
    mem_wb_reg_rd_adr           = rd;
    mem_wb_reg_byte_ofs         = ofs;
    mem_wb_reg_wb_ctrl_MemTrim  = trim;
    mem_wb_reg_wb_ctrl_MemSign  = sign;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] val);
    mem_wb_reg_valid            = 1'b1;
    mem_wb_reg_wb_ctrl_MemtoReg = 1'b0;
    mem_wb_reg_wb_ctrl_RegWrite = 1'b1;
    mem_wb_reg_rd_adr           = rd;
    mem_wb_reg_alu_result       = val;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic        sign;
    logic [1:0]  trim;
    logic [1:0]  ofs;
    logic        done;
    logic [31:0] data;
  } mload_t;

  mload_t mq[$];
  logic   m_err;

  function automatic logic [31:0] mext(input logic [31:0] d, input logic [1:0] trim,
                                       input logic [1:0] ofs, input logic sign);
    logic [31:0] v;
    if (trim == 2'b10) begin
      v = (d >> (8 * int'(ofs))) & 32'h0000_00FF;
      if (sign && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (trim == 2'b01) begin
      v = (d >> (16 * int'(ofs[1]))) & 32'h0000_FFFF;
      if (sign && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) if (mq[i].we) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  function automatic int m_first_undone();
    foreach (mq[i]) if (!mq[i].done) return i;
    return -1;
  endfunction

  task automatic run_random(input int ncycles);
    logic [31:0] pend;
    logic        alu_wr, retire, full_pre, exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          idx;
    mload_t      e;
    for (int c = 0; c < ncycles; c++) begin
      pend = m_pending();
      idle();
      if ($urandom_range(3) != 0) begin
        mem_wb_reg_valid            = 1'b1;
        mem_wb_reg_wb_ctrl_MemtoReg = ($urandom_range(2) == 0) && (mq.size() < LQ_DEPTH);
        mem_wb_reg_wb_ctrl_RegWrite = ($urandom_range(4) != 0);
        mem_wb_reg_alu_result       = $urandom;
        mem_wb_reg_byte_ofs         = 2'($urandom_range(3));
        mem_wb_reg_wb_ctrl_MemTrim  = 2'($urandom_range(3));
        mem_wb_reg_wb_ctrl_MemSign  = 1'($urandom_range(1));
        mem_wb_reg_rd_adr           = 5'($urandom_range(31));
        for (int k = 0; k < 64 && pend[mem_wb_reg_rd_adr]; k++)
          mem_wb_reg_rd_adr = 5'($urandom_range(31));
      end
      if (m_first_undone() >= 0 && $urandom_range(1) == 1) begin
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = $urandom;
      end
      if (mem_wb_reg_valid && mem_wb_reg_wb_ctrl_RegWrite && mem_wb_reg_rd_adr != 0 &&
          pend[mem_wb_reg_rd_adr]) begin
        fails++;
        $display("FAIL waw_stimulus: rd %0d issued while pending", mem_wb_reg_rd_adr);
      end

      full_pre = (mq.size() == LQ_DEPTH);
      alu_wr   = mem_wb_reg_valid && !mem_wb_reg_wb_ctrl_MemtoReg &&
                 mem_wb_reg_wb_ctrl_RegWrite && mem_wb_reg_rd_adr != 0;
      retire   = !alu_wr && mq.size() > 0 && mq[0].done;
      exp_we = 1'b0; exp_rd = '0; exp_data = '0;
      if (alu_wr) begin
        exp_we = 1'b1; exp_rd = mem_wb_reg_rd_adr; exp_data = mem_wb_reg_alu_result;
      end else if (retire) begin
        exp_we = mq[0].we; exp_rd = mq[0].rd; exp_data = mq[0].data;
      end

      #1;
      chk("rnd_we", wb_stage_wb_ctrl_RegWrite, exp_we);
      if (alu_wr || retire) begin
        chk("rnd_rd", wb_stage_rd_adr, exp_rd);
        chk("rnd_data", wb_stage_reg_file_wr_data, exp_data);
      end
      chk("rnd_full", wb_stage_lq_full, full_pre);
      chk("rnd_empty", wb_stage_lq_empty, mq.size() == 0);
      chk("rnd_pending", wb_stage_rd_pending, pend);
      chk("rnd_err", wb_stage_lq_err, m_err);

      if (dmem_rsp_valid) begin
        idx = m_first_undone();
        if (idx < 0) m_err = 1'b1;
        else begin
          mq[idx].done = 1'b1;
          mq[idx].data = mext(dmem_rsp_data, mq[idx].trim, mq[idx].ofs, mq[idx].sign);
        end
      end
      if (retire) void'(mq.pop_front());
      if (mem_wb_reg_valid && mem_wb_reg_wb_ctrl_MemtoReg) begin
        if (full_pre) m_err = 1'b1;
        else begin
          e.rd = mem_wb_reg_rd_adr; e.sign = mem_wb_reg_wb_ctrl_MemSign;
          e.trim = mem_wb_reg_wb_ctrl_MemTrim; e.ofs = mem_wb_reg_byte_ofs;
          e.we = mem_wb_reg_wb_ctrl_RegWrite && mem_wb_reg_rd_adr != 0;
          e.done = 1'b0; e.data = '0;
          mq.push_back(e);
        end
      end
      tick();
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        exp_we;
    logic [31:0] exp_data;
  } alu_vec_t;

  typedef struct packed {
    logic [1:0]  trim;
    logic        sign;
    logic [1:0]  ofs;
    logic [31:0] rsp;
    logic [31:0] exp;
  } ld_vec_t;

  alu_vec_t alu_tab [5];
  ld_vec_t  ld_tab  [12];

  task automatic fill_drain(input int round);
    for (int i = 0; i < 4; i++) begin
      idle();
      set_load(5'(10 + i), 2'd0, TRIM_WORD, 1'b0);
      #1;
      chk("fd_not_full", wb_stage_lq_full, 1'b0);
      tick();
    end
    idle();
    #1;
    chk("fd_full", wb_stage_lq_full, 1'b1);
    chk("fd_pending", wb_stage_rd_pending, 32'h0000_3C00);
    set_load(5'd20, 2'd0, TRIM_WORD, 1'b0);
    tick();
    idle();
    #1;
    chk("fd_overflow_err", wb_stage_lq_err, 1'b1);
    chk("fd_overflow_dropped", wb_stage_rd_pending, 32'h0000_3C00);
    for (int i = 0; i <= 4; i++) begin
      idle();
      if (i < 4) begin
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'hA000_0000 | (round << 4) | i;
      end
      #1;
      if (i == 0) begin
        chk("fd_no_bypass", wb_stage_wb_ctrl_RegWrite, 1'b0);
      end else begin
        chk("fd_ret_we", wb_stage_wb_ctrl_RegWrite, 1'b1);
        chk("fd_ret_rd", wb_stage_rd_adr, 10 + i - 1);
        chk("fd_ret_data", wb_stage_reg_file_wr_data, 32'hA000_0000 | (round << 4) | (i - 1));
        if (i == 1) chk("fd_full_during_retire", wb_stage_lq_full, 1'b1);
      end
      tick();
    end
    #1;
    chk("fd_empty", wb_stage_lq_empty, 1'b1);
    chk("fd_idle_we", wb_stage_wb_ctrl_RegWrite, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_tab[0] = '{1'b1, 1'b1, 5'd5,  32'h0000_1234, 1'b1, 32'h0000_1234};
    alu_tab[1] = '{1'b1, 1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 32'h0};
    alu_tab[2] = '{1'b1, 1'b0, 5'd9,  32'h0000_0055, 1'b0, 32'h0};
    alu_tab[3] = '{1'b0, 1'b1, 5'd9,  32'h0000_0077, 1'b0, 32'h0};
    alu_tab[4] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};

    ld_tab[0]  = '{TRIM_BYTE, 1'b1, 2'd2, 32'h1280_3456, 32'hFFFF_FF80};
    ld_tab[1]  = '{TRIM_BYTE, 1'b0, 2'd2, 32'h1280_3456, 32'h0000_0080};
    ld_tab[2]  = '{TRIM_BYTE, 1'b1, 2'd0, 32'h1280_3456, 32'h0000_0056};
    ld_tab[3]  = '{TRIM_BYTE, 1'b1, 2'd3, 32'h9280_3456, 32'hFFFF_FF92};
    ld_tab[4]  = '{TRIM_BYTE, 1'b0, 2'd1, 32'h1280_3456, 32'h0000_0034};
    ld_tab[5]  = '{TRIM_HALF, 1'b0, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF};
    ld_tab[6]  = '{TRIM_HALF, 1'b1, 2'd2, 32'hBEEF_0000, 32'hFFFF_BEEF};
    ld_tab[7]  = '{TRIM_HALF, 1'b1, 2'd3, 32'hBEEF_1234, 32'hFFFF_BEEF};
    ld_tab[8]  = '{TRIM_HALF, 1'b1, 2'd1, 32'h0000_8001, 32'hFFFF_8001};
    ld_tab[9]  = '{TRIM_HALF, 1'b1, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF};
    ld_tab[10] = '{TRIM_WORD, 1'b1, 2'd3, 32'h8000_0001, 32'h8000_0001};
    ld_tab[11] = '{2'b11,     1'b1, 2'd2, 32'h1234_5678, 32'h1234_5678};

    idle();
    rst_n = 1'b0;
    tick();
    chk("rst_full", wb_stage_lq_full, 1'b0);
    chk("rst_empty", wb_stage_lq_empty, 1'b1);
    chk("rst_pending", wb_stage_rd_pending, 32'h0);
    chk("rst_err", wb_stage_lq_err, 1'b0);
    chk("rst_we", wb_stage_wb_ctrl_RegWrite, 1'b0);
    rst_n = 1'b1;
    tick();

    // ALU path, combinational
    for (int i = 0; i < 5; i++) begin
      idle();
      mem_wb_reg_valid            = alu_tab[i].valid;
      mem_wb_reg_wb_ctrl_RegWrite = alu_tab[i].regwrite;
      mem_wb_reg_rd_adr           = alu_tab[i].rd;
      mem_wb_reg_alu_result       = alu_tab[i].alu;
      #1;
      chk("alu_we", wb_stage_wb_ctrl_RegWrite, alu_tab[i].exp_we);
      if (alu_tab[i].exp_we) begin
        chk("alu_rd", wb_stage_rd_adr, alu_tab[i].rd);
        chk("alu_data", wb_stage_reg_file_wr_data, alu_tab[i].exp_data);
      end
      tick();
    end

    // Lane extraction through full load round trips
    for (int i = 0; i < 12; i++) begin
      idle();
      set_load(5'd9, ld_tab[i].ofs, ld_tab[i].trim, ld_tab[i].sign);
      tick();
      idle();
      tick();
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = ld_tab[i].rsp;
      tick();
      idle();
      #1;
      chk("ld_we", wb_stage_wb_ctrl_RegWrite, 1'b1);
      chk("ld_rd", wb_stage_rd_adr, 5'd9);
      chk("ld_data", wb_stage_reg_file_wr_data, ld_tab[i].exp);
      tick();
    end

    // Signed byte load with pending tracking
    idle();
    set_load(5'd7, 2'd2, TRIM_BYTE, 1'b1);
    #1;
    chk("lb_pend_not_yet", wb_stage_rd_pending[7], 1'b0);
    tick();
    idle();
    #1;
    chk("lb_pend_issue", wb_stage_rd_pending[7], 1'b1);
    chk("lb_not_empty", wb_stage_lq_empty, 1'b0);
    tick();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h1280_3456;
    #1;
    chk("lb_no_bypass", wb_stage_wb_ctrl_RegWrite, 1'b0);
    chk("lb_pend_rsp", wb_stage_rd_pending[7], 1'b1);
    tick();
    idle();
    #1;
    chk("lb_we", wb_stage_wb_ctrl_RegWrite, 1'b1);
    chk("lb_rd", wb_stage_rd_adr, 5'd7);
    chk("lb_data", wb_stage_reg_file_wr_data, 32'hFFFF_FF80);
    chk("lb_pend_retire", wb_stage_rd_pending[7], 1'b1);
    tick();
    chk("lb_pend_clear", wb_stage_rd_pending, 32'h0);
    chk("lb_empty", wb_stage_lq_empty, 1'b1);

    // Unsigned half load blocked by ALU writers
    idle();
    set_load(5'd3, 2'd2, TRIM_HALF, 1'b0);
    tick();
    idle();
    set_alu(5'd4, 32'h0000_0011);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'hBEEF_0000;
    #1;
    chk("lhu_alu1_rd", wb_stage_rd_adr, 5'd4);
    chk("lhu_alu1_data", wb_stage_reg_file_wr_data, 32'h0000_0011);
    tick();
    idle();
    set_alu(5'd4, 32'h0000_0022);
    #1;
    chk("lhu_alu2_rd", wb_stage_rd_adr, 5'd4);
    chk("lhu_alu2_data", wb_stage_reg_file_wr_data, 32'h0000_0022);
    chk("lhu_still_pending", wb_stage_rd_pending[3], 1'b1);
    tick();
    idle();
    #1;
    chk("lhu_we", wb_stage_wb_ctrl_RegWrite, 1'b1);
    chk("lhu_rd", wb_stage_rd_adr, 5'd3);
    chk("lhu_data", wb_stage_reg_file_wr_data, 32'h0000_BEEF);
    tick();
    chk("lhu_err_clean", wb_stage_lq_err, 1'b0);

    // Two fill/drain rounds, exercising pointer and count wrap
    fill_drain(0);
    fill_drain(1);

    // Spurious response on an empty queue
    do_reset();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h5555_AAAA;
    #1;
    chk("spur_no_write", wb_stage_wb_ctrl_RegWrite, 1'b0);
    tick();
    idle();
    chk("spur_err", wb_stage_lq_err, 1'b1);
    tick();
    tick();
    chk("spur_err_sticky", wb_stage_lq_err, 1'b1);

    // Reset with three loads outstanding
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      set_load(5'(5 + i), 2'd0, TRIM_WORD, 1'b0);
      tick();
    end
    idle();
    #1;
    chk("mid_pending_before", wb_stage_rd_pending, 32'h0000_00E0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pending", wb_stage_rd_pending, 32'h0);
    chk("mid_rst_empty", wb_stage_lq_empty, 1'b1);
    chk("mid_rst_err", wb_stage_lq_err, 1'b0);
    tick();
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h0BAD_0BAD;
    #1;
    chk("mid_late_rsp_no_write", wb_stage_wb_ctrl_RegWrite, 1'b0);
    tick();
    idle();
    #1;
    chk("mid_late_rsp_err", wb_stage_lq_err, 1'b1);
    chk("mid_late_no_retire", wb_stage_wb_ctrl_RegWrite, 1'b0);

    // Randomised traffic against the queue model
    do_reset();
    mq.delete();
    m_err = 1'b0;
    run_random(1500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
